touch_event_mp: RTL
===================

Name: touch_event_mp

Overview:
- Multi-point touch event engine that sits after the GT-series touch controller.
- Converts the per-report point snapshot (point count plus packed XY for up to MAX_PTS points) into a queue of DOWN/MOVE/UP events with a movement threshold.
- Exposes the queue and status through an Avalon-MM slave with an interrupt, replacing the single-point tp1_xy path for multi-touch UI logic.

Parameters:
MAX_PTS, 5, number of touch point slots tracked (1..7).
NUM_W, 3, width of tp_num; must hold MAX_PTS.
FIFO_DEPTH, 16, event FIFO entries; power of two, 4..64.
MOVE_TH_RST, 4, reset value of the MOVE_TH register.

Ports:
sys_clk  in  1  single clock for all logic.
sys_rst  in  1  synchronous reset, active-high.
frame_vld  in  1  one-cycle strobe; tp_num/tp_xy valid this cycle.
tp_num  in  NUM_W  active point count in this report.
tp_xy  in  32*MAX_PTS  point i at [32i+31:32i], x=[31:16], y=[15:0].
avl_address  in  3  register word address.
avl_write  in  1  write request.
avl_writedata  in  32  write data.
avl_read  in  1  read request.
avl_readdata  out  32  registered read data.
irq  out  1  level interrupt.

Behaviour:
- Reset: all outputs 0, FIFO empty, all slots inactive, sticky flags 0, CTRL=0x5 (enable=1, irq_en=0, move_en=1), MOVE_TH=MOVE_TH_RST, FSM=IDLE.
- Slot i is active in a report iff i < min(tp_num, MAX_PTS); a tp_num above MAX_PTS is clamped.
- FSM IDLE:
  - frame_vld with enable=1: snapshot tp_num/tp_xy and go to SCAN with idx=0.
  - frame_vld with enable=0: ignored.
- FSM SCAN (one slot per cycle): slot idx is evaluated in cycle idx+1 after frame_vld, and any event is pushed that same cycle. The engine returns to IDLE after idx=MAX_PTS-1; it is busy for MAX_PTS cycles.
- Per-slot evaluation:
  - inactive→active: push DOWN (type 01) with the new XY; ref_xy and live_xy take the new XY.
  - active→active: if move_en and (|x-ref_x| > MOVE_TH or |y-ref_y| > MOVE_TH), strictly greater, unsigned 16-bit difference: push MOVE (10) and ref_xy takes the new XY. live_xy always takes the new XY.
  - active→inactive: push UP (11) with the last live_xy.
  - inactive→inactive: nothing.
- frame_vld while in SCAN: report dropped, FRAME_DROP sticky bit set.
- FIFO entry: {type[1:0], id[2:0], xy[31:0]}.
- FIFO full on push: event discarded, OVF sticky bit set. A same-cycle pop and push on a full FIFO is accepted with no OVF.
- Writing enable 1→0 marks all slots inactive with no UP events; the FIFO is untouched.
- Register map (word address):
  - 0 STATUS (RO): [15:8] FIFO count, [2] FRAME_DROP, [1] OVF, [0] not_empty.
  - 1 EVT_HDR (RO): [4:2] id, [1:0] type of the head entry; 0 if empty; no pop.
  - 2 EVT_XY (RO): head xy; the read pops the entry if not empty; returns 0 if empty.
  - 3 CTRL (RW): [0] enable, [1] irq_en, [2] move_en.
  - 4 MOVE_TH (RW): [15:0].
  - 5 CLR (WO): bit1=1 clears OVF, bit2=1 clears FRAME_DROP; reads 0.
  - 6 LIVE (RO): [MAX_PTS-1:0] active slot mask.
  - 7: reads 0.
- avl_readdata: updated one cycle after avl_read and held otherwise. The pop takes effect in the same cycle the data is registered.
- Simultaneous avl_read and avl_write: both take effect.
- A sticky flag set and a CLR write in the same cycle: set wins.
- irq is registered: irq = irq_en & (not_empty | OVF), one cycle after the cause.
- sys_rst mid-SCAN aborts the scan and clears all state to reset values.

Test Plan:
- Reset, then read addr 0/3/4 → 0x0, 0x5, 0x4; irq=0.
- frame_vld with tp_num=2, p0=(100,200), p1=(300,400) → after 5 cycles, count=2. HDR then XY reads return (id0,DOWN)/0x006400C8, then (id1,DOWN)/0x012C0190; count returns to 0.
- Next frame with p0=(104,200), then p0=(105,200) with MOVE_TH=4 → first frame no event; second frame MOVE id0, xy 0x006900C8.
- tp_num=0 after the above → UP id0 (xy 0x006900C8) and UP id1 (xy 0x012C0190); LIVE=0.
- 17 DOWN-producing events with no reads and irq_en=1 → count=16, OVF=1, irq=1; CLR write 0x2 after draining → OVF=0, irq=0.
- frame_vld at cycles 0 and 2; tp_num=7 with MAX_PTS=5 → second report dropped and FRAME_DROP=1; only slots 0..4 active; sys_rst at cycle 3 → all state at reset values.

Source files
------------

// File: rtl/touch_event_mp.sv
// Multi-point touch event engine: turns per-report point snapshots into a
// DOWN/MOVE/UP event FIFO with an Avalon-MM register interface and interrupt.
module touch_event_mp #(
  parameter int MAX_PTS     = 5,
  parameter int NUM_W       = 3,
  parameter int FIFO_DEPTH  = 16,
  parameter int MOVE_TH_RST = 4
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic                   frame_vld,
  input  logic [NUM_W-1:0]       tp_num,
  input  logic [32*MAX_PTS-1:0]  tp_xy,
  input  logic [2:0]             avl_address,
  input  logic                   avl_write,
  input  logic [31:0]            avl_writedata,
  input  logic                   avl_read,
  output logic [31:0]            avl_readdata,
  output logic                   irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [0:0] {IDLE = 1'b0, SCAN = 1'b1} state_t;

  state_t            state_r;
  logic [2:0]        idx_r;
  logic [2:0]        snap_num_r;
  logic [31:0]       snap_pt_r [MAX_PTS];
  logic [MAX_PTS-1:0] active_r;
  logic [31:0]       ref_xy_r  [MAX_PTS];
  logic [31:0]       live_xy_r [MAX_PTS];
  logic [36:0]       fifo_mem_r [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]     count_r;
  logic [2:0]        ctrl_r;
  logic [15:0]       move_th_r;
  logic              ovf_r, drop_r, irq_r;
  logic [31:0]       readdata_r;

  logic [NUM_W-1:0]  num_clamp_s;
  logic [31:0]       cur_xy_s, ref_sel_s, evt_xy_s, rd_mux_s;
  logic [15:0]       dx_s, dy_s;
  logic              new_act_s, old_act_s, over_s, push_s, push_ok_s, pop_s;
  logic              empty_s, full_s, ovf_set_s, drop_set_s, disable_s, clr_wr_s;
  logic [1:0]        evt_type_s;
  logic [36:0]       head_s;
  logic              unused_wdata_s;

  assign unused_wdata_s = &{1'b0, avl_writedata[31:16]};

  // Slot evaluation datapath: clamp, current point selection, threshold compare
  always_comb begin
    num_clamp_s = (tp_num > NUM_W'(MAX_PTS)) ? NUM_W'(MAX_PTS) : tp_num;
    cur_xy_s    = snap_pt_r[idx_r];
    ref_sel_s   = ref_xy_r[idx_r];
    new_act_s   = (idx_r < snap_num_r);
    old_act_s   = active_r[idx_r];
    dx_s = (cur_xy_s[31:16] >= ref_sel_s[31:16]) ? (cur_xy_s[31:16] - ref_sel_s[31:16])
                                                 : (ref_sel_s[31:16] - cur_xy_s[31:16]);
    dy_s = (cur_xy_s[15:0] >= ref_sel_s[15:0]) ? (cur_xy_s[15:0] - ref_sel_s[15:0])
                                               : (ref_sel_s[15:0] - cur_xy_s[15:0]);
    over_s = (dx_s > move_th_r) || (dy_s > move_th_r);
  end

  // Event classification for the slot under scan
  always_comb begin
    push_s     = 1'b0;
    evt_type_s = 2'b00;
    evt_xy_s   = cur_xy_s;
    if (state_r == SCAN) begin
      if (new_act_s && !old_act_s) begin
        push_s     = 1'b1;
        evt_type_s = 2'b01;
      end else if (new_act_s && old_act_s) begin
        if (ctrl_r[2] && over_s) begin
          push_s     = 1'b1;
          evt_type_s = 2'b10;
        end else begin
          push_s = 1'b0;
        end
      end else if (old_act_s) begin
        push_s     = 1'b1;
        evt_type_s = 2'b11;
        evt_xy_s   = live_xy_r[idx_r];
      end else begin
        push_s = 1'b0;
      end
    end else begin
      push_s = 1'b0;
    end
  end

  // FIFO handshake and register-side control strobes
  always_comb begin
    head_s     = fifo_mem_r[rd_ptr_r];
    empty_s    = (count_r == '0);
    full_s     = (count_r == FULL_CNT);
    pop_s      = avl_read && (avl_address == 3'd2) && !empty_s;
    push_ok_s  = push_s && (!full_s || pop_s);
    ovf_set_s  = push_s && full_s && !pop_s;
    drop_set_s = frame_vld && (state_r == SCAN);
    disable_s  = avl_write && (avl_address == 3'd3) && ctrl_r[0] && !avl_writedata[0];
    clr_wr_s   = avl_write && (avl_address == 3'd5);
  end

  // Read data multiplexer
  always_comb begin
    rd_mux_s = 32'd0;
    case (avl_address)
      3'd0:    rd_mux_s = {16'd0, 8'(count_r), 5'd0, drop_r, ovf_r, !empty_s};
      3'd1:    rd_mux_s = empty_s ? 32'd0 : {27'd0, head_s[34:32], head_s[36:35]};
      3'd2:    rd_mux_s = empty_s ? 32'd0 : head_s[31:0];
      3'd3:    rd_mux_s = {29'd0, ctrl_r};
      3'd4:    rd_mux_s = {16'd0, move_th_r};
      3'd6:    rd_mux_s = 32'(active_r);
      default: rd_mux_s = 32'd0;
    endcase
  end

  // FIFO storage
  always_ff @(posedge sys_clk) begin
    if (push_ok_s) begin
      fifo_mem_r[wr_ptr_r] <= {evt_type_s, idx_r, evt_xy_s};
    end
  end

  // Scan FSM, slot tracking, FIFO pointers, registers and outputs
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_r    <= IDLE;
      idx_r      <= 3'd0;
      snap_num_r <= 3'd0;
      active_r   <= '0;
      for (int i = 0; i < MAX_PTS; i++) begin
        snap_pt_r[i] <= 32'd0;
        ref_xy_r[i]  <= 32'd0;
        live_xy_r[i] <= 32'd0;
      end
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      ctrl_r     <= 3'b101;
      move_th_r  <= 16'(MOVE_TH_RST);
      ovf_r      <= 1'b0;
      drop_r     <= 1'b0;
      readdata_r <= 32'd0;
      irq_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (frame_vld && ctrl_r[0]) begin
            state_r    <= SCAN;
            idx_r      <= 3'd0;
            snap_num_r <= 3'(num_clamp_s);
            for (int i = 0; i < MAX_PTS; i++) snap_pt_r[i] <= tp_xy[32*i +: 32];
          end
        end
        SCAN: begin
          active_r[idx_r] <= new_act_s;
          if (new_act_s) live_xy_r[idx_r] <= cur_xy_s;
          if (push_s && (evt_type_s != 2'b11)) ref_xy_r[idx_r] <= cur_xy_s;
          idx_r <= idx_r + 3'd1;
          if (idx_r == 3'(MAX_PTS - 1)) state_r <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
      // Disabling forgets every contact silently; queued events stay.
      if (disable_s) active_r <= '0;

      if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)     rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_ok_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase

      if (ovf_set_s) ovf_r <= 1'b1;
      else if (clr_wr_s && avl_writedata[1]) ovf_r <= 1'b0;
      if (drop_set_s) drop_r <= 1'b1;
      else if (clr_wr_s && avl_writedata[2]) drop_r <= 1'b0;

      if (avl_write && (avl_address == 3'd3)) ctrl_r    <= avl_writedata[2:0];
      if (avl_write && (avl_address == 3'd4)) move_th_r <= avl_writedata[15:0];
      if (avl_read) readdata_r <= rd_mux_s;
      irq_r <= ctrl_r[1] && (!empty_s || ovf_r);
    end
  end

  assign avl_readdata = readdata_r;
  assign irq          = irq_r;

endmodule
